// File: rtl/rtc_mch_cnt.sv
// -----------------------------------------------------------------------------
// rtc_mch_cnt
//
// Always-on RTC counter with a prescaler, a CNT_W-bit up-counter that either
// wraps or saturates, and NUM_CH independent match channels. Each channel is
// one-shot (disables itself on a hit) or periodic (advances its match value by
// its period on a hit). Raw match flags are sticky until cleared by a
// write-one-to-clear pulse; masked status drives the VIC interrupt line, and
// any unmasked hit produces a one-cycle ETB trigger pulse.
//
// Ports
//   pclk               sole clock, all state on the rising edge
//   rtc_por_rst        synchronous active-high reset, clears every register
//   pdu_aou_pwdata     write data shared by all write strobes
//   pdu_aou_wen_cr     write control: [0] cnt_en, [1] wrap_en, [2] intr_en
//   pdu_aou_wen_div    write prescaler divide value (pwdata[DIV_W-1:0])
//   pdu_aou_wen_clr    load counter with pwdata, clear ovf, restart prescaler
//   pdu_aou_ch_sel     channel for per-channel writes and match readback
//   pdu_aou_wen_mr     write match value of the selected channel
//   pdu_aou_wen_prd    write period (reload increment) of the selected channel
//   pdu_aou_wen_chcr   write channel control: [0] ch_en, [1] periodic, [2] mask
//   pdu_aou_int_clr    per-channel W1C pulse for the raw flags
//   etb_rtc_trig       external start pulse, sets cnt_en
//   aou_pdu_cnt        current count
//   aou_pdu_cr_reg     {ovf, intr_en, wrap_en, cnt_en}
//   aou_pdu_div_reg    prescaler divide value
//   aou_pdu_mr_reg     match value of the selected channel (combinational)
//   aou_pdu_int_raw    raw match flags
//   aou_pdu_int_stat   raw & ~mask
//   rtc0_vic_intr      level interrupt, intr_en & |stat
//   rtc_etb_trig       registered one-cycle pulse on any unmasked hit
//   rtc_tick           prescaler tick (combinational from registers)
// -----------------------------------------------------------------------------
module rtc_mch_cnt #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DIV_W    = 20,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_IDX_W = 2
) (
    input  logic                pclk,
    input  logic                rtc_por_rst,
    input  logic [CNT_W-1:0]    pdu_aou_pwdata,
    input  logic                pdu_aou_wen_cr,
    input  logic                pdu_aou_wen_div,
    input  logic                pdu_aou_wen_clr,
    input  logic [CH_IDX_W-1:0] pdu_aou_ch_sel,
    input  logic                pdu_aou_wen_mr,
    input  logic                pdu_aou_wen_prd,
    input  logic                pdu_aou_wen_chcr,
    input  logic [NUM_CH-1:0]   pdu_aou_int_clr,
    input  logic                etb_rtc_trig,
    output logic [CNT_W-1:0]    aou_pdu_cnt,
    output logic [3:0]          aou_pdu_cr_reg,
    output logic [DIV_W-1:0]    aou_pdu_div_reg,
    output logic [CNT_W-1:0]    aou_pdu_mr_reg,
    output logic [NUM_CH-1:0]   aou_pdu_int_raw,
    output logic [NUM_CH-1:0]   aou_pdu_int_stat,
    output logic                rtc0_vic_intr,
    output logic                rtc_etb_trig,
    output logic                rtc_tick
);

    // Global state
    logic [CNT_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_reg;
    logic              cnt_en;
    logic              wrap_en;
    logic              intr_en;
    logic              ovf;
    logic              etb_q;

    // Per-channel state
    logic [CNT_W-1:0]  mr  [NUM_CH];
    logic [CNT_W-1:0]  prd [NUM_CH];
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] periodic;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] raw;

    // Combinational helpers
    logic              tick;
    logic              at_max;
    logic              steps;
    logic [CNT_W-1:0]  cnt_inc;
    logic [NUM_CH-1:0] ch_wsel;
    logic [NUM_CH-1:0] hit;
    logic [CNT_W-1:0]  mr_mux;

    // ------------------------------------------------------------------
    // Tick and match decode
    // ------------------------------------------------------------------
    always_comb begin
        tick    = cnt_en & (div_cnt == div_reg);
        at_max  = &cnt;
        cnt_inc = cnt + CNT_W'(1);
        // The counter only "steps" (and is thus match-eligible) when it
        // actually changes: a saturating hold or a same-cycle load does not.
        steps   = tick & ~pdu_aou_wen_clr & (~at_max | wrap_en);
        ch_wsel = '0;
        hit     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_wsel[i] = (pdu_aou_ch_sel == CH_IDX_W'(i));
            hit[i]     = steps & ch_en[i] & (cnt_inc == mr[i]);
        end
    end

    // Match readback; out-of-range selects read as zero.
    always_comb begin
        mr_mux = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pdu_aou_ch_sel == CH_IDX_W'(i)) begin
                mr_mux = mr[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rtc_por_rst) begin
            cnt      <= '0;
            div_cnt  <= '0;
            div_reg  <= '0;
            cnt_en   <= 1'b0;
            wrap_en  <= 1'b0;
            intr_en  <= 1'b0;
            ovf      <= 1'b0;
            etb_q    <= 1'b0;
            ch_en    <= '0;
            periodic <= '0;
            mask     <= '0;
            raw      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mr[i]  <= '0;
                prd[i] <= '0;
            end
        end else begin
            // Prescaler: restarts on any divide write or counter load.
            if (pdu_aou_wen_div | pdu_aou_wen_clr) begin
                div_cnt <= '0;
            end else if (tick) begin
                div_cnt <= '0;
            end else if (cnt_en) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (pdu_aou_wen_div) begin
                div_reg <= pdu_aou_pwdata[DIV_W-1:0];
            end

            // Counter: a load overrides the tick.
            if (pdu_aou_wen_clr) begin
                cnt <= pdu_aou_pwdata;
                ovf <= 1'b0;
            end else if (tick) begin
                if (!at_max || wrap_en) begin
                    cnt <= cnt_inc;
                end
                if (at_max) begin
                    ovf <= 1'b1;
                end
            end

            // Control: a register write beats the external start pulse.
            if (pdu_aou_wen_cr) begin
                cnt_en  <= pdu_aou_pwdata[0];
                wrap_en <= pdu_aou_pwdata[1];
                intr_en <= pdu_aou_pwdata[2];
            end else if (etb_rtc_trig) begin
                cnt_en <= 1'b1;
            end

            // Channels: software writes win over hit side effects.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (pdu_aou_wen_mr && ch_wsel[i]) begin
                    mr[i] <= pdu_aou_pwdata;
                end else if (hit[i] && periodic[i]) begin
                    mr[i] <= mr[i] + prd[i];
                end

                if (pdu_aou_wen_prd && ch_wsel[i]) begin
                    prd[i] <= pdu_aou_pwdata;
                end

                if (pdu_aou_wen_chcr && ch_wsel[i]) begin
                    ch_en[i]    <= pdu_aou_pwdata[0];
                    periodic[i] <= pdu_aou_pwdata[1];
                    mask[i]     <= pdu_aou_pwdata[2];
                end else if (hit[i] && !periodic[i]) begin
                    ch_en[i] <= 1'b0;
                end
            end

            // Set beats clear.
            raw   <= (raw & ~pdu_aou_int_clr) | hit;
            etb_q <= |(hit & ~mask);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign aou_pdu_cnt      = cnt;
    assign aou_pdu_cr_reg   = {ovf, intr_en, wrap_en, cnt_en};
    assign aou_pdu_div_reg  = div_reg;
    assign aou_pdu_mr_reg   = mr_mux;
    assign aou_pdu_int_raw  = raw;
    assign aou_pdu_int_stat = raw & ~mask;
    assign rtc0_vic_intr    = intr_en & (|(raw & ~mask));
    assign rtc_etb_trig     = etb_q;
    assign rtc_tick         = tick;

endmodule

// File: tb/tb_rtc_mch_cnt.sv
// -----------------------------------------------------------------------------
// tb_rtc_mch_cnt
//
// Directed bench for rtc_mch_cnt with the default parameters (32-bit counter,
// 20-bit prescaler, 4 channels). Inputs change 1 time unit after each rising
// edge; outputs are checked at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_rtc_mch_cnt;

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned DIV_W    = 20;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_IDX_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [CNT_W-1:0]    pwdata;
    logic                wen_cr;
    logic                wen_div;
    logic                wen_clr;
    logic [CH_IDX_W-1:0] ch_sel;
    logic                wen_mr;
    logic                wen_prd;
    logic                wen_chcr;
    logic [NUM_CH-1:0]   int_clr;
    logic                trig_in;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          cr_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [CNT_W-1:0]    mr_reg;
    logic [NUM_CH-1:0]   int_raw;
    logic [NUM_CH-1:0]   int_stat;
    logic                vic;
    logic                etb;
    logic                tick;

    int errors = 0;
    int checks = 0;

    rtc_mch_cnt #(
        .CNT_W(CNT_W),
        .DIV_W(DIV_W),
        .NUM_CH(NUM_CH),
        .CH_IDX_W(CH_IDX_W)
    ) dut (
        .pclk(clk),
        .rtc_por_rst(rst),
        .pdu_aou_pwdata(pwdata),
        .pdu_aou_wen_cr(wen_cr),
        .pdu_aou_wen_div(wen_div),
        .pdu_aou_wen_clr(wen_clr),
        .pdu_aou_ch_sel(ch_sel),
        .pdu_aou_wen_mr(wen_mr),
        .pdu_aou_wen_prd(wen_prd),
        .pdu_aou_wen_chcr(wen_chcr),
        .pdu_aou_int_clr(int_clr),
        .etb_rtc_trig(trig_in),
        .aou_pdu_cnt(cnt),
        .aou_pdu_cr_reg(cr_reg),
        .aou_pdu_div_reg(div_reg),
        .aou_pdu_mr_reg(mr_reg),
        .aou_pdu_int_raw(int_raw),
        .aou_pdu_int_stat(int_stat),
        .rtc0_vic_intr(vic),
        .rtc_etb_trig(etb),
        .rtc_tick(tick)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_cr(input logic [31:0] d);
        pwdata = d; wen_cr = 1'b1; cyc(); wen_cr = 1'b0;
    endtask

    task automatic wr_div(input logic [31:0] d);
        pwdata = d; wen_div = 1'b1; cyc(); wen_div = 1'b0;
    endtask

    task automatic wr_clr(input logic [31:0] d);
        pwdata = d; wen_clr = 1'b1; cyc(); wen_clr = 1'b0;
    endtask

    task automatic wr_mr(input logic [1:0] ch, input logic [31:0] d);
        ch_sel = ch; pwdata = d; wen_mr = 1'b1; cyc(); wen_mr = 1'b0;
    endtask

    task automatic wr_prd(input logic [1:0] ch, input logic [31:0] d);
        ch_sel = ch; pwdata = d; wen_prd = 1'b1; cyc(); wen_prd = 1'b0;
    endtask

    task automatic wr_chcr(input logic [1:0] ch, input logic [31:0] d);
        ch_sel = ch; pwdata = d; wen_chcr = 1'b1; cyc(); wen_chcr = 1'b0;
    endtask

    task automatic clr_all();
        int_clr = 4'hF; cyc(); int_clr = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},  cnt,      32'h0);
        chk({tag, "_cr"},   cr_reg,   32'h0);
        chk({tag, "_div"},  div_reg,  32'h0);
        chk({tag, "_mr"},   mr_reg,   32'h0);
        chk({tag, "_raw"},  int_raw,  32'h0);
        chk({tag, "_stat"}, int_stat, 32'h0);
        chk({tag, "_vic"},  vic,      32'h0);
        chk({tag, "_etb"},  etb,      32'h0);
        chk({tag, "_tick"}, tick,     32'h0);
    endtask

    initial begin
        rst = 1'b1; pwdata = '0; wen_cr = 1'b0; wen_div = 1'b0; wen_clr = 1'b0;
        ch_sel = '0; wen_mr = 1'b0; wen_prd = 1'b0; wen_chcr = 1'b0;
        int_clr = '0; trig_in = 1'b0;

        // Reset state
        cyc(); cyc();
        chk_all_zero("rst");
        rst = 1'b0;

        // Prescaler div=3: one tick in four cycles, cnt=5 after 20 cycles
        wr_div(3);
        wr_clr(0);
        wr_cr(3);
        chk("pre_div", div_reg, 3);
        chk("pre_cr", cr_reg, 4'b0011);
        chk("pre_cnt0", cnt, 0);
        chk("pre_tick0", tick, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk("pre_tick", tick, ((k % 4) == 3) ? 1 : 0);
            chk("pre_cnt", cnt, k / 4);
        end
        wr_cr(0);

        // One-shot channel 0 at 10, div=0
        wr_div(0);
        wr_mr(0, 10);
        wr_chcr(0, 1);
        wr_clr(0);
        wr_cr(7);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("os_raw_pre", int_raw, 0);
            chk("os_etb_pre", etb, 0);
        end
        cyc();
        chk("os_cnt", cnt, 10);
        chk("os_raw", int_raw, 4'b0001);
        chk("os_stat", int_stat, 4'b0001);
        chk("os_vic", vic, 1);
        chk("os_etb", etb, 1);
        cyc();
        chk("os_etb_end", etb, 0);
        chk("os_vic_hold", vic, 1);
        int_clr = 4'b0001; cyc(); int_clr = '0;
        chk("os_clr_raw", int_raw, 0);
        chk("os_clr_vic", vic, 0);
        wr_clr(32'hFFFF_FFFD);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("os_wrap_raw", int_raw, 0);
            chk("os_wrap_etb", etb, 0);
        end
        chk("os_wrap_cnt", cnt, 32'h0000_000D);
        chk("os_wrap_cr", cr_reg, 4'hF);
        wr_cr(0);

        // Periodic channel 1, mr=4 prd=4
        wr_mr(1, 4);
        wr_prd(1, 4);
        wr_chcr(1, 3);
        wr_clr(0);
        wr_cr(3);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("per_raw_pre", int_raw, 0);
        end
        cyc();
        chk("per_cnt4", cnt, 4);
        chk("per_raw4", int_raw, 4'b0010);
        chk("per_stat4", int_stat, 4'b0010);
        chk("per_etb4", etb, 1);
        chk("per_mr8", mr_reg, 8);
        chk("per_vic_off", vic, 0);
        int_clr = 4'b0010; cyc(); int_clr = '0;
        chk("per_clr_raw", int_raw, 0);
        chk("per_etb_end", etb, 0);
        cyc(); cyc();
        int_clr = 4'b0010; cyc(); int_clr = '0;
        chk("per_cnt8", cnt, 8);
        chk("per_setwins", int_raw, 4'b0010);
        chk("per_mr12", mr_reg, 12);
        chk("per_etb8", etb, 1);
        cyc(); cyc(); cyc(); cyc();
        chk("per_cnt12", cnt, 12);
        chk("per_mr16", mr_reg, 16);
        chk("per_etb12", etb, 1);
        wr_cr(0);
        wr_chcr(1, 0);
        clr_all();

        // Saturate without wrap: mr=0 channel must not hit
        wr_mr(3, 0);
        wr_chcr(3, 1);
        wr_clr(32'hFFFF_FFFE);
        wr_cr(1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("sat_raw", int_raw, 0);
            chk("sat_etb", etb, 0);
        end
        chk("sat_cnt", cnt, 32'hFFFF_FFFF);
        chk("sat_cr", cr_reg, 4'b1001);

        // Same with wrap: counter rolls to 0 and mr=0 channel hits
        wr_cr(3);
        wr_clr(32'hFFFF_FFFE);
        chk("wrap_ovf_clr", cr_reg, 4'b0011);
        cyc();
        chk("wrap_cnt_max", cnt, 32'hFFFF_FFFF);
        chk("wrap_raw_pre", int_raw, 0);
        cyc();
        chk("wrap_cnt0", cnt, 0);
        chk("wrap_cr", cr_reg, 4'b1011);
        chk("wrap_raw", int_raw, 4'b1000);
        chk("wrap_etb", etb, 1);
        wr_cr(0);
        clr_all();

        // Masked channel 2, counter started by external trigger
        wr_mr(2, 3);
        wr_chcr(2, 5);
        wr_cr(4);
        wr_clr(0);
        trig_in = 1'b1; cyc(); trig_in = 1'b0;
        chk("trig_cr", cr_reg, 4'b0101);
        chk("trig_cnt0", cnt, 0);
        cyc();
        chk("trig_cnt1", cnt, 1);
        cyc();
        chk("trig_cnt2", cnt, 2);
        cyc();
        chk("mask_cnt", cnt, 3);
        chk("mask_raw", int_raw, 4'b0100);
        chk("mask_stat", int_stat, 0);
        chk("mask_vic", vic, 0);
        chk("mask_etb", etb, 0);
        cyc();
        chk("mask_etb_after", etb, 0);
        pwdata = 0; wen_cr = 1'b1; trig_in = 1'b1;
        cyc();
        wen_cr = 1'b0; trig_in = 1'b0;
        chk("cr_beats_trig", cr_reg, 0);
        clr_all();

        // Reset while vic_intr is high, mid-prescale, with a hit pending
        wr_mr(0, 1);
        wr_chcr(0, 1);
        wr_mr(1, 2);
        wr_chcr(1, 1);
        wr_div(3);
        wr_clr(0);
        wr_cr(5);
        cyc(); cyc(); cyc(); cyc();
        chk("rr_cnt1", cnt, 1);
        chk("rr_raw", int_raw, 4'b0001);
        chk("rr_vic", vic, 1);
        chk("rr_etb", etb, 1);
        cyc(); cyc(); cyc();
        chk("rr_vic_hold", vic, 1);
        chk("rr_tick", tick, 1);
        chk("rr_etb_idle", etb, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ch_sel = 0;
        #1;
        chk_all_zero("rr");
        cyc(); cyc(); cyc();
        chk("rr_idle_cnt", cnt, 0);
        chk("rr_idle_tick", tick, 0);
        chk("rr_idle_cr", cr_reg, 0);
        wr_cr(1);
        chk("rr_en_cnt0", cnt, 0);
        cyc(); cyc(); cyc();
        chk("rr_resume_cnt", cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
